ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 132 +++++++++++++
 tb/tb_ex_mem_reg.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a data-memory request FSM and an optional
// EX/MEM forwarding source (enabled by defining EX_MEM_FWD_EN).
module ex_mem_reg (
  input  logic        CLK,
  input  logic        RST,
  input  logic        jal_ex,
  input  logic        jalr_ex,
  input  logic        auipc_ex,
  input  logic        lui_ex,
  input  logic        WEN_ex,
  input  logic        memtoreg_ex,
  input  logic        dREN_ex,
  input  logic        dWEN_ex,
  input  logic        halt_ex,
  input  logic [31:0] presult_ex,
  input  logic [31:0] imm_ex,
  input  logic [31:0] imemaddr_ex,
  input  logic [31:0] imemload_ex,
  input  logic [31:0] storedata_ex,
  input  logic [4:0]  rd_ex,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        flush_ex,
  input  logic        stall_ex,
  input  logic [31:0] dmemload,
  output logic        jal_mem,
  output logic        jalr_mem,
  output logic        auipc_mem,
  output logic        lui_mem,
  output logic        WEN_mem,
  output logic        memtoreg_mem,
  output logic        dREN_mem,
  output logic        dWEN_mem,
  output logic        halt_mem,
  output logic [31:0] presult_mem,
  output logic [31:0] imm_mem,
  output logic [31:0] imemaddr_mem,
  output logic [31:0] imemload_mem,
  output logic [31:0] storedata_mem,
  output logic [4:0]  rd_mem,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic [31:0] dmemload_mem,
  output logic        mem_busy,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [1:0]  state_dbg   // 0 = IDLE, 1 = REQ, 2 = DONE
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t state;
  logic   advance;

  // Handshake: the memory request is held (dmemREN/dmemWEN high) while in REQ
  // until dhit; the pipe advances only when ihit=1, stall_ex=0, mem_busy=0 and
  // the register is not halted, so a REQ that sees dhit releases the pipe at once.
  assign mem_busy  = (state == REQ) & ~dhit;
  assign advance   = ihit & ~stall_ex & ~mem_busy & ~halt_mem;
  assign state_dbg = state;

  assign dmemREN   = (state == REQ) & dREN_mem;
  assign dmemWEN   = (state == REQ) & dWEN_mem;
  assign dmemaddr  = (state == REQ) ? presult_mem   : 32'd0;
  assign dmemstore = (state == REQ) ? storedata_mem : 32'd0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      {jal_mem, jalr_mem, auipc_mem, lui_mem, WEN_mem, memtoreg_mem,
       dREN_mem, dWEN_mem, halt_mem} <= '0;
      presult_mem   <= '0;
      imm_mem       <= '0;
      imemaddr_mem  <= '0;
      imemload_mem  <= '0;
      storedata_mem <= '0;
      rd_mem        <= '0;
      dmemload_mem  <= '0;
      state         <= IDLE;
    end else if (!halt_mem) begin
      if (state == REQ && dhit) begin
        if (dREN_mem) dmemload_mem <= dmemload;
        state <= DONE;
      end
      // A later assignment to state wins when the pipe advances on the hit cycle.
      if (advance) begin
        if (flush_ex) begin
          {jal_mem, jalr_mem, auipc_mem, lui_mem, WEN_mem, memtoreg_mem,
           dREN_mem, dWEN_mem, halt_mem} <= '0;
          presult_mem   <= '0;
          imm_mem       <= '0;
          imemaddr_mem  <= '0;
          imemload_mem  <= '0;
          storedata_mem <= '0;
          rd_mem        <= '0;
          state         <= IDLE;
        end else begin
          jal_mem       <= jal_ex;
          jalr_mem      <= jalr_ex;
          auipc_mem     <= auipc_ex;
          lui_mem       <= lui_ex;
          WEN_mem       <= WEN_ex;
          memtoreg_mem  <= memtoreg_ex;
          dREN_mem      <= dREN_ex;
          dWEN_mem      <= dWEN_ex;
          halt_mem      <= halt_ex;
          presult_mem   <= presult_ex;
          imm_mem       <= imm_ex;
          imemaddr_mem  <= imemaddr_ex;
          imemload_mem  <= imemload_ex;
          storedata_mem <= storedata_ex;
          rd_mem        <= rd_ex;
          state         <= (dREN_ex | dWEN_ex) ? REQ : IDLE;
        end
      end
    end
  end

`ifdef EX_MEM_FWD_EN
  // A load result is only forwardable once the data has come back.
  assign fwd_valid = WEN_mem & (rd_mem != 5'd0) & ~(memtoreg_mem & (state != DONE));
  assign fwd_rd    = rd_mem;
  assign fwd_data  = memtoreg_mem ? dmemload_mem : presult_mem;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: table vectors, hand-written multi-cycle sequences and
// randomized cycles checked against a transaction-level reference model.
module tb_ex_mem_reg;

`ifdef EX_MEM_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  typedef struct packed {
    logic        jal, jalr, auipc, lui, wen, m2r, dren, dwen, halt;
    logic [31:0] presult, imm, imemaddr, imemload, storedata;
    logic [4:0]  rd;
  } ex_t;

  typedef struct packed {
    ex_t         mem;
    logic [31:0] load;
    logic        ren, wen, busy;
    logic [31:0] addr, store;
    logic        fv;
    logic [4:0]  frd;
    logic [31:0] fdata;
  } obs_t;

  typedef struct {
    logic [31:0] presult, store;
    logic [4:0]  rd;
    logic        wen, m2r, dren, dwen, flush;
    logic [31:0] e_presult;
    logic        e_wen, e_ren, e_dwen, e_busy, e_fv;
    logic [31:0] e_addr;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  ex_t         ex;
  logic        ihit, dhit, flush_ex, stall_ex;
  logic [31:0] dmemload;

  logic        jal_mem, jalr_mem, auipc_mem, lui_mem, WEN_mem, memtoreg_mem;
  logic        dREN_mem, dWEN_mem, halt_mem;
  logic [31:0] presult_mem, imm_mem, imemaddr_mem, imemload_mem, storedata_mem;
  logic [4:0]  rd_mem;
  logic        dmemREN, dmemWEN, mem_busy, fwd_valid;
  logic [31:0] dmemaddr, dmemstore, dmemload_mem, fwd_data;
  logic [4:0]  fwd_rd;
  logic [1:0]  state_dbg;

  obs_t obs_act;

  int n_cmp = 0;
  int n_bad = 0;
  logic [$bits(obs_t)-1:0] exp_q[$];

  // reference model: the instruction held in MEM plus its memory transaction status
  ex_t         m_f;
  logic [31:0] m_load;
  bit          m_out;   // request issued, data not yet returned
  bit          m_srv;   // request of the current instruction has completed

  ex_mem_reg dut (
    .CLK(CLK), .RST(RST),
    .jal_ex(ex.jal), .jalr_ex(ex.jalr), .auipc_ex(ex.auipc), .lui_ex(ex.lui),
    .WEN_ex(ex.wen), .memtoreg_ex(ex.m2r), .dREN_ex(ex.dren), .dWEN_ex(ex.dwen),
    .halt_ex(ex.halt), .presult_ex(ex.presult), .imm_ex(ex.imm),
    .imemaddr_ex(ex.imemaddr), .imemload_ex(ex.imemload),
    .storedata_ex(ex.storedata), .rd_ex(ex.rd),
    .ihit(ihit), .dhit(dhit), .flush_ex(flush_ex), .stall_ex(stall_ex),
    .dmemload(dmemload),
    .jal_mem(jal_mem), .jalr_mem(jalr_mem), .auipc_mem(auipc_mem), .lui_mem(lui_mem),
    .WEN_mem(WEN_mem), .memtoreg_mem(memtoreg_mem), .dREN_mem(dREN_mem),
    .dWEN_mem(dWEN_mem), .halt_mem(halt_mem), .presult_mem(presult_mem),
    .imm_mem(imm_mem), .imemaddr_mem(imemaddr_mem), .imemload_mem(imemload_mem),
    .storedata_mem(storedata_mem), .rd_mem(rd_mem),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmemload_mem(dmemload_mem), .mem_busy(mem_busy),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    obs_act       = '0;
    obs_act.mem   = {jal_mem, jalr_mem, auipc_mem, lui_mem, WEN_mem, memtoreg_mem,
                     dREN_mem, dWEN_mem, halt_mem, presult_mem, imm_mem,
                     imemaddr_mem, imemload_mem, storedata_mem, rd_mem};
    obs_act.load  = dmemload_mem;
    obs_act.ren   = dmemREN;
    obs_act.wen   = dmemWEN;
    obs_act.busy  = mem_busy;
    obs_act.addr  = dmemaddr;
    obs_act.store = dmemstore;
    obs_act.fv    = fwd_valid;
    obs_act.frd   = fwd_rd;
    obs_act.fdata = fwd_data;
  end

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o       = '0;
    o.mem   = m_f;
    o.load  = m_load;
    o.ren   = m_out & m_f.dren;
    o.wen   = m_out & m_f.dwen;
    o.busy  = m_out & ~dhit;
    o.addr  = m_out ? m_f.presult : 32'd0;
    o.store = m_out ? m_f.storedata : 32'd0;
    if (FWD_ON) begin
      o.fv    = m_f.wen & (m_f.rd != 5'd0) & ~(m_f.m2r & ~m_srv);
      o.frd   = m_f.rd;
      o.fdata = m_f.m2r ? m_load : m_f.presult;
    end
    return o;
  endfunction

  task automatic model_step();
    bit busy, adv;
    if (RST) begin
      m_f = '0; m_load = '0; m_out = 0; m_srv = 0;
    end else if (!m_f.halt) begin
      busy = m_out & ~dhit;
      adv  = ihit & ~stall_ex & ~busy;
      if (m_out && dhit) begin
        if (m_f.dren) m_load = dmemload;
        m_out = 0;
        m_srv = 1;
      end
      if (adv) begin
        m_f   = flush_ex ? '0 : ex;
        m_out = ~flush_ex & (ex.dren | ex.dwen);
        m_srv = 0;
      end
    end
  endtask

  // one clock: update the model with the inputs applied this cycle, then
  // return at the following falling edge ready for new inputs
  task automatic step();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    ex = '0; ihit = 0; dhit = 0; flush_ex = 0; stall_ex = 0; RST = 0; dmemload = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    #1;
    step();
    RST = 0;
  endtask

  task automatic rand_inputs();
    ex.jal       = ($urandom_range(0, 9) == 0);
    ex.jalr      = ($urandom_range(0, 9) == 0);
    ex.auipc     = ($urandom_range(0, 9) == 0);
    ex.lui       = ($urandom_range(0, 9) == 0);
    ex.wen       = ($urandom_range(0, 1) == 0);
    ex.m2r       = ($urandom_range(0, 2) == 0);
    ex.dren      = ($urandom_range(0, 3) == 0);
    ex.dwen      = ($urandom_range(0, 3) == 0);
    ex.halt      = ($urandom_range(0, 59) == 0);
    ex.presult   = $urandom;
    ex.imm       = $urandom;
    ex.imemaddr  = $urandom;
    ex.imemload  = $urandom;
    ex.storedata = $urandom;
    ex.rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    ihit         = ($urandom_range(0, 9) < 8);
    dhit         = ($urandom_range(0, 9) < 4);
    flush_ex     = ($urandom_range(0, 9) < 2);
    stall_ex     = ($urandom_range(0, 9) < 2);
    RST          = ($urandom_range(0, 39) == 0);
    dmemload     = $urandom;
  endtask

  vec_t vecs[6];

  initial begin
    idle_inputs();
    m_f = '0; m_load = '0; m_out = 0; m_srv = 0;
    RST = 1;
    @(negedge CLK);
    step();
    RST = 0;
    #1;
    chk("reset_outputs", obs_act, '0);
    chk("reset_state", 320'(state_dbg), 320'd0);

    // presult, store, rd, wen, m2r, dren, dwen, flush | e_presult, e_wen, e_ren, e_dwen, e_busy, e_fv, e_addr
    vecs[0] = '{32'h10, 32'h0,    5'd5, 1, 0, 0, 0, 0, 32'h10, 1, 0, 0, 0, 1, 32'h0};
    vecs[1] = '{32'h80, 32'h0,    5'd3, 1, 1, 1, 0, 0, 32'h80, 1, 1, 0, 1, 0, 32'h80};
    vecs[2] = '{32'h44, 32'h1234, 5'd0, 0, 0, 0, 1, 0, 32'h44, 0, 0, 1, 1, 0, 32'h44};
    vecs[3] = '{32'h99, 32'h55,   5'd7, 1, 0, 0, 1, 1, 32'h0,  0, 0, 0, 0, 0, 32'h0};
    vecs[4] = '{32'h20, 32'h0,    5'd0, 1, 0, 0, 0, 0, 32'h20, 1, 0, 0, 0, 0, 32'h0};
    vecs[5] = '{32'h30, 32'h0,    5'd2, 1, 1, 0, 0, 0, 32'h30, 1, 0, 0, 0, 0, 32'h0};

    for (int i = 0; i < 6; i++) begin
      do_reset();
      ex.presult = vecs[i].presult; ex.storedata = vecs[i].store; ex.rd = vecs[i].rd;
      ex.wen = vecs[i].wen; ex.m2r = vecs[i].m2r; ex.dren = vecs[i].dren;
      ex.dwen = vecs[i].dwen; flush_ex = vecs[i].flush; ihit = 1;
      #1;
      step();
      idle_inputs();
      #1;
      chk($sformatf("vec%0d_presult_mem", i), 320'(presult_mem), 320'(vecs[i].e_presult));
      chk($sformatf("vec%0d_WEN_mem", i), 320'(WEN_mem), 320'(vecs[i].e_wen));
      chk($sformatf("vec%0d_dmemREN", i), 320'(dmemREN), 320'(vecs[i].e_ren));
      chk($sformatf("vec%0d_dmemWEN", i), 320'(dmemWEN), 320'(vecs[i].e_dwen));
      chk($sformatf("vec%0d_dmemaddr", i), 320'(dmemaddr), 320'(vecs[i].e_addr));
      chk($sformatf("vec%0d_mem_busy", i), 320'(mem_busy), 320'(vecs[i].e_busy));
      chk($sformatf("vec%0d_fwd_valid", i), 320'(fwd_valid), 320'(vecs[i].e_fv & FWD_ON));
    end

    // load held for three miss cycles, then a hit without advancing
    do_reset();
    ex.dren = 1; ex.presult = 32'h80; ex.rd = 5'd4; ex.wen = 1; ex.m2r = 1; ihit = 1;
    #1;
    step();
    ex = '0; ihit = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("load_wait%0d_ren", i), 320'(dmemREN), 320'd1);
      chk($sformatf("load_wait%0d_addr", i), 320'(dmemaddr), 320'h80);
      chk($sformatf("load_wait%0d_busy", i), 320'(mem_busy), 320'd1);
      chk($sformatf("load_wait%0d_held", i), 320'(presult_mem), 320'h80);
      step();
    end
    ihit = 0; dhit = 1; dmemload = 32'hDEADBEEF;
    #1;
    chk("load_hit_busy", 320'(mem_busy), 320'd0);
    step();
    dhit = 0;
    #1;
    chk("load_data", 320'(dmemload_mem), 320'hDEADBEEF);
    chk("load_done_ren", 320'(dmemREN), 320'd0);
    chk("load_done_state", 320'(state_dbg), 320'd2);
    chk("load_done_fwd_valid", 320'(fwd_valid), 320'(FWD_ON));
    chk("load_done_fwd_data", 320'(fwd_data), FWD_ON ? 320'hDEADBEEF : 320'd0);
    dhit = 1; dmemload = 32'h1;
    #1;
    step();
    dhit = 0;
    #1;
    chk("done_no_reissue_ren", 320'(dmemREN), 320'd0);
    chk("done_keeps_data", 320'(dmemload_mem), 320'hDEADBEEF);

    // new load, then its hit coincides with advancing a store
    ex.dren = 1; ex.presult = 32'h90; ihit = 1;
    #1;
    step();
    ex = '0; ex.dwen = 1; ex.presult = 32'hA0; ex.storedata = 32'h5A;
    ihit = 1; dhit = 1; dmemload = 32'hCAFEF00D;
    #1;
    chk("hit_adv_busy", 320'(mem_busy), 320'd0);
    step();
    idle_inputs();
    #1;
    chk("hit_adv_load", 320'(dmemload_mem), 320'hCAFEF00D);
    chk("hit_adv_state", 320'(state_dbg), 320'd1);
    chk("hit_adv_wen", 320'(dmemWEN), 320'd1);
    chk("hit_adv_addr", 320'(dmemaddr), 320'hA0);
    chk("hit_adv_store", 320'(dmemstore), 320'h5A);

    // flush bubble: no store request may appear
    do_reset();
    ex.wen = 1; ex.dwen = 1; ex.rd = 5'd9; ex.presult = 32'h123; flush_ex = 1; ihit = 1;
    #1;
    step();
    idle_inputs();
    #1;
    chk("flush_WEN_mem", 320'(WEN_mem), 320'd0);
    chk("flush_dWEN_mem", 320'(dWEN_mem), 320'd0);
    chk("flush_state", 320'(state_dbg), 320'd0);
    chk("flush_dmemWEN", 320'(dmemWEN), 320'd0);

    // stall holds for four cycles while EX keeps changing
    do_reset();
    ex.presult = 32'h11; ex.rd = 5'd6; ex.wen = 1; ihit = 1;
    #1;
    step();
    stall_ex = 1;
    for (int i = 0; i < 4; i++) begin
      ex.presult = $urandom; ex.rd = 5'($urandom_range(1, 31)); ex.jal = 1;
      #1;
      step();
      #1;
      chk($sformatf("stall%0d_presult", i), 320'(presult_mem), 320'h11);
      chk($sformatf("stall%0d_rd", i), 320'(rd_mem), 320'd6);
    end
    stall_ex = 0; ex.presult = 32'h22; ex.rd = 5'd8;
    #1;
    step();
    #1;
    chk("unstall_presult", 320'(presult_mem), 320'h22);
    chk("unstall_rd", 320'(rd_mem), 320'd8);

    // reset while a store is outstanding
    do_reset();
    ex.dwen = 1; ex.presult = 32'h40; ex.storedata = 32'h77; ihit = 1;
    #1;
    step();
    ex = '0; ex.wen = 1; ex.presult = 32'h5; ihit = 1;
    #1;
    chk("store_pending_wen", 320'(dmemWEN), 320'd1);
    RST = 1;
    #1;
    step();
    idle_inputs();
    #1;
    chk("rst_mid_store_outputs", obs_act, '0);
    chk("rst_mid_store_wen", 320'(dmemWEN), 320'd0);
    chk("rst_mid_store_busy", 320'(mem_busy), 320'd0);

    // halt is sticky until reset
    do_reset();
    ex.halt = 1; ex.presult = 32'h77; ex.rd = 5'd3; ex.wen = 1; ihit = 1;
    #1;
    step();
    #1;
    chk("halt_set", 320'(halt_mem), 320'd1);
    for (int i = 0; i < 3; i++) begin
      ex.halt = 0; ex.presult = $urandom; ex.rd = 5'd12; ihit = 1;
      #1;
      step();
      #1;
      chk($sformatf("halt_hold%0d_presult", i), 320'(presult_mem), 320'h77);
      chk($sformatf("halt_hold%0d_halt", i), 320'(halt_mem), 320'd1);
    end
    do_reset();
    #1;
    chk("halt_cleared", obs_act, '0);

    // randomized cycles against the reference model
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      #1;
      exp_q.push_back(model_obs());
      chk($sformatf("rand_cycle%0d", c), obs_act, exp_q.pop_front());
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
